// File: rtl/parallel_bitcoin_hash_pkg.sv
// -----------------------------------------------------------------------------
// parallel_bitcoin_hash_pkg
// Shared SHA-256 definitions for the nonce search co-processor:
//   - round constants K[0:63] and the standard initial hash value IV
//   - rotate, small/big sigma helpers, the single-round operator sha256_op
//     and the 8-word digest adder add8
//   - the controller state enum
// State vectors are packed {a,b,c,d,e,f,g,h} with a in the top word; message
// blocks are packed with word 0 in the top 32 bits.
// -----------------------------------------------------------------------------
package parallel_bitcoin_hash_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_BLK1,
      ST_BLK2,
      ST_HASH2,
      ST_WRITE,
      ST_DONE
   } state_e;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] PAD_WORD = 32'h8000_0000;

   function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   function automatic logic [255:0] sha256_op(input logic [255:0] st,
                                              input logic [31:0]  w,
                                              input logic [31:0]  k);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = st;
      t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
      t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
      end
      return r;
   endfunction

endpackage

// File: rtl/parallel_bitcoin_hash_core.sv
// -----------------------------------------------------------------------------
// sha256_core
// One SHA-256 compression engine, one round per cycle.
//   clk, rst_n   clock, asynchronous active-low reset (clears all state)
//   load_i       capture init_i as both working and chaining state, block_i
//                into the schedule window (has priority over step_i)
//   step_i       perform round round_i and slide the schedule window
//   round_i      round index 0..63 selecting K
//   init_i       256-bit initial state {a..h}
//   block_i      512-bit message block, word 0 in the top bits
//   digest_o     chaining state + working state (valid after 64 steps)
// -----------------------------------------------------------------------------
module sha256_core
   import parallel_bitcoin_hash_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         step_i,
   input  logic [5:0]   round_i,
   input  logic [255:0] init_i,
   input  logic [511:0] block_i,
   output logic [255:0] digest_o
);

   logic [255:0] init_q, init_d;
   logic [255:0] state_q, state_d;
   logic [31:0]  win_q [16];
   logic [31:0]  win_d [16];
   logic [31:0]  w_new;

   // The window always holds W[t..t+15]; each step consumes W[t] and appends
   // W[t+16], so the expander runs one step ahead of what it strictly needs.
   always_comb begin
      init_d  = init_q;
      state_d = state_q;
      for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
      w_new = win_q[0] + ssig0(win_q[1]) + win_q[9] + ssig1(win_q[14]);
      if (load_i) begin
         init_d  = init_i;
         state_d = init_i;
         for (int i = 0; i < 16; i++) win_d[i] = block_i[511 - 32*i -: 32];
      end else if (step_i) begin
         state_d = sha256_op(state_q, win_q[0], K[round_i]);
         for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
         win_d[15] = w_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q  <= '0;
         state_q <= '0;
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
      end else begin
         init_q  <= init_d;
         state_q <= state_d;
         for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
      end
   end

   assign digest_o = add8(init_q, state_q);

endmodule

// File: rtl/parallel_bitcoin_hash.sv
// -----------------------------------------------------------------------------
// parallel_bitcoin_hash
// Double-SHA-256 nonce search: reads a 19-word header, computes the first-block
// midstate on core 0, then hashes nonces 0..NUM_NONCES-1 in lock-step and
// writes H0 of each final digest to output_addr+n.
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 level, sampled only in IDLE
//   message_addr          header base address (latched on start)
//   output_addr           result base address (latched on start)
//   done                  one-cycle pulse after the last result write
//   mem_clk               memory clock (= clk)
//   mem_we/addr/write_data/read_data   single-port SRAM, 1-cycle read latency
// Build option: PBH_MIDSTATE_WRITEBACK_EN also writes the 8 midstate words to
// output_addr+NUM_NONCES+0..7 after the H0 words.
// -----------------------------------------------------------------------------
module parallel_bitcoin_hash
   import parallel_bitcoin_hash_pkg::*;
#(
   parameter int NUM_NONCES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] message_addr,
   input  logic [15:0] output_addr,
   output logic        done,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam int CNT_W     = 8;
   localparam int HDR_WORDS = 19;
   localparam int RND_LAST  = 64;
   localparam int IDX_W     = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
`ifdef PBH_MIDSTATE_WRITEBACK_EN
   localparam int WR_LEN    = NUM_NONCES + 8;
`else
   localparam int WR_LEN    = NUM_NONCES;
`endif

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        maddr_q, maddr_d;
   logic [15:0]        oaddr_q, oaddr_d;
   logic               done_q, done_d;
   logic [31:0]        hdr_q [HDR_WORDS];
   logic [4:0]         hdr_idx;
   logic [CNT_W-1:0]   rd_idx;
   logic [IDX_W-1:0]   nonce_idx;
   logic [31:0]        wr_data;

   logic [NUM_NONCES-1:0] load;
   logic                  step;
   logic [255:0]          core_init  [NUM_NONCES];
   logic [511:0]          core_block [NUM_NONCES];
   logic [255:0]          digest     [NUM_NONCES];

   assign mem_clk   = clk;
   assign done      = done_q;
   assign hdr_idx   = 5'(cnt_q - CNT_W'(1));
   assign rd_idx    = (cnt_q < CNT_W'(HDR_WORDS)) ? cnt_q : CNT_W'(HDR_WORDS - 1);
   assign nonce_idx = cnt_q[IDX_W-1:0];

   // Controller: every phase counts from 0; hash phases spend 0..63 on rounds
   // and count 64 on the final addition, consumed at the phase-exit edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      maddr_d = maddr_q;
      oaddr_d = oaddr_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start) begin
               maddr_d = message_addr;
               oaddr_d = output_addr;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (cnt_q == CNT_W'(HDR_WORDS)) begin
               state_d = ST_BLK1;
               cnt_d   = '0;
            end
         end
         ST_BLK1: begin
            if (cnt_q == CNT_W'(RND_LAST)) begin
               state_d = ST_BLK2;
               cnt_d   = '0;
            end
         end
         ST_BLK2: begin
            if (cnt_q == CNT_W'(RND_LAST)) begin
               state_d = ST_HASH2;
               cnt_d   = '0;
            end
         end
         ST_HASH2: begin
            if (cnt_q == CNT_W'(RND_LAST)) begin
               state_d = ST_WRITE;
               cnt_d   = '0;
            end
         end
         ST_WRITE: begin
            if (cnt_q == CNT_W'(WR_LEN - 1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         maddr_q <= '0;
         oaddr_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         maddr_q <= maddr_d;
         oaddr_q <= oaddr_d;
         done_q  <= done_d;
      end
   end

   // Read data for the address issued at count c arrives at count c+1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < HDR_WORDS; i++) hdr_q[i] <= '0;
      end else if (state_q == ST_READ && cnt_q != '0) begin
         hdr_q[hdr_idx] <= mem_read_data;
      end
   end

`ifdef PBH_MIDSTATE_WRITEBACK_EN
   logic [31:0] mid_q [8];
   logic [2:0]  mid_idx;

   assign mid_idx = 3'(cnt_q - CNT_W'(NUM_NONCES));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) mid_q[i] <= '0;
      end else if (state_q == ST_BLK1 && cnt_q == CNT_W'(RND_LAST)) begin
         for (int i = 0; i < 8; i++) mid_q[i] <= digest[0][255 - 32*i -: 32];
      end
   end

   always_comb begin
      wr_data = digest[nonce_idx][255:224];
      if (cnt_q >= CNT_W'(NUM_NONCES)) wr_data = mid_q[mid_idx];
   end
`else
   assign wr_data = digest[nonce_idx][255:224];
`endif

   always_comb begin
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      case (state_q)
         ST_READ:  mem_addr = maddr_q + 16'(rd_idx);
         ST_WRITE: begin
            mem_we         = 1'b1;
            mem_addr       = oaddr_q + 16'(cnt_q);
            mem_write_data = wr_data;
         end
         default: ;
      endcase
   end

   // Core loading happens on each phase-exit edge so the next phase starts
   // rounding immediately; the midstate and digests feed loads combinationally.
   always_comb begin
      step = ((state_q == ST_BLK1) || (state_q == ST_BLK2) || (state_q == ST_HASH2)) &&
             (cnt_q < CNT_W'(RND_LAST));
      for (int n = 0; n < NUM_NONCES; n++) begin
         load[n]       = 1'b0;
         core_init[n]  = IV;
         core_block[n] = '0;
      end
      case (state_q)
         ST_READ: begin
            load[0] = (cnt_q == CNT_W'(HDR_WORDS));
            for (int i = 0; i < 16; i++) core_block[0][511 - 32*i -: 32] = hdr_q[i];
         end
         ST_BLK1: begin
            for (int n = 0; n < NUM_NONCES; n++) begin
               load[n]       = (cnt_q == CNT_W'(RND_LAST));
               core_init[n]  = digest[0];
               core_block[n] = {hdr_q[16], hdr_q[17], hdr_q[18], 32'(n), PAD_WORD,
                                320'h0, 32'd640};
            end
         end
         ST_BLK2: begin
            for (int n = 0; n < NUM_NONCES; n++) begin
               load[n]       = (cnt_q == CNT_W'(RND_LAST));
               core_block[n] = {digest[n], PAD_WORD, 192'h0, 32'd256};
            end
         end
         default: ;
      endcase
   end

   for (genvar n = 0; n < NUM_NONCES; n++) begin : g_core
      sha256_core u_core (
         .clk      (clk),
         .rst_n    (reset_n),
         .load_i   (load[n]),
         .step_i   (step),
         .round_i  (cnt_q[5:0]),
         .init_i   (core_init[n]),
         .block_i  (core_block[n]),
         .digest_o (digest[n])
      );
   end

endmodule

// File: tb/tb_parallel_bitcoin_hash.sv
`timescale 1ns/1ps
module tb_parallel_bitcoin_hash;

   localparam int NN = 16;
`ifdef PBH_MIDSTATE_WRITEBACK_EN
   localparam int NW  = NN + 8;
   localparam int LAT = 240;
`else
   localparam int NW  = NN;
   localparam int LAT = 232;
`endif

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] IV_T = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   typedef struct {
      logic [15:0]  maddr;
      logic [15:0]  oaddr;
      int           hold;
      bit           repulse;
      logic [607:0] hdr;
      logic [511:0] exp;
      logic [255:0] mid;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] message_addr = '0;
   logic [15:0] output_addr = '0;
   logic        done, mem_clk, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:65535];
   logic        bd_we = 1'b0;
   logic [15:0] bd_addr = '0;
   logic [31:0] bd_data = '0;
   logic [15:0] win_base = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_cnt = 0, bad_wr = 0, done_cnt = 0, last_done_cyc = 0;

   vec_t tab [4];

   always #5 clk = ~clk;

   parallel_bitcoin_hash #(.NUM_NONCES(NN)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .message_addr   (message_addr),
      .output_addr    (output_addr),
      .done           (done),
      .mem_clk        (mem_clk),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   // Synchronous SRAM with a bench-side backdoor write port.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (mem_we) mem[mem_addr] <= mem_write_data;
      mem_read_data <= mem[mem_addr];
   end

   always @(negedge clk) begin
      if (mem_we) begin
         wr_cnt <= wr_cnt + 1;
         if (16'(mem_addr - win_base) >= 16'(NW)) bad_wr <= bad_wr + 1;
      end
      if (done) begin
         done_cnt      <= done_cnt + 1;
         last_done_cyc <= cyc;
      end
   end

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference compression in the textbook form: full 64-word schedule array,
   // working variables in an array shifted each round.
   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] s0, s1, t1, t2;
      logic [255:0] r;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) +
              ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) +
              ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = v[i] + hin[255 - 32*i -: 32];
      return r;
   endfunction

   task automatic model(input logic [607:0] h, output logic [511:0] exp, output logic [255:0] mid);
      logic [511:0] b;
      logic [255:0] d, f;
      for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = h[32*i +: 32];
      mid = compress(IV_T, b);
      exp = '0;
      for (int n = 0; n < NN; n++) begin
         b = {h[16*32 +: 32], h[17*32 +: 32], h[18*32 +: 32], 32'(n), 32'h8000_0000, 320'h0, 32'd640};
         d = compress(mid, b);
         b = {d, 32'h8000_0000, 192'h0, 32'd256};
         f = compress(IV_T, b);
         exp[32*n +: 32] = f[255:224];
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic bd_write(input logic [15:0] a, input logic [31:0] d);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = d;
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   task automatic load_vec(input int r);
      for (int i = 0; i < 19; i++) bd_write(tab[r].maddr + 16'(i), tab[r].hdr[32*i +: 32]);
      for (int i = 0; i < NW; i++) bd_write(tab[r].oaddr + 16'(i), 32'hDEAD_0000 | 32'(i));
      win_base = tab[r].oaddr;
   endtask

   task automatic run_vec(input int r);
      int w0, d0, b0, t0;
      load_vec(r);
      @(negedge clk);
      w0 = wr_cnt; d0 = done_cnt; b0 = bad_wr;
      message_addr = tab[r].maddr;
      output_addr  = tab[r].oaddr;
      start        = 1'b1;
      t0           = cyc + 1;
      repeat (tab[r].hold) @(negedge clk);
      start = 1'b0;
      if (tab[r].repulse) begin
         while (cyc - t0 < 100) @(negedge clk);
         message_addr = 16'h1234;
         output_addr  = 16'h4321;
         start        = 1'b1;
         @(negedge clk);
         start        = 1'b0;
      end
      while (done_cnt == d0 && cyc - t0 < LAT + 50) @(negedge clk);
      chk($sformatf("v%0d_done_seen", r), 32'(done_cnt != d0), 32'd1);
      chk($sformatf("v%0d_latency", r), 32'(last_done_cyc - t0), 32'(LAT));
      repeat (40) @(negedge clk);
      chk($sformatf("v%0d_done_pulses", r), 32'(done_cnt - d0), 32'd1);
      chk($sformatf("v%0d_write_count", r), 32'(wr_cnt - w0), 32'(NW));
      chk($sformatf("v%0d_stray_writes", r), 32'(bad_wr - b0), 32'd0);
      for (int n = 0; n < NN; n++)
         chk($sformatf("v%0d_h0_n%0d", r, n), mem[tab[r].oaddr + 16'(n)], tab[r].exp[32*n +: 32]);
`ifdef PBH_MIDSTATE_WRITEBACK_EN
      for (int i = 0; i < 8; i++)
         chk($sformatf("v%0d_mid%0d", r, i), mem[tab[r].oaddr + 16'(NN + i)], tab[r].mid[255 - 32*i -: 32]);
`endif
      for (int i = 0; i < 19; i++)
         chk($sformatf("v%0d_hdr%0d", r, i), mem[tab[r].maddr + 16'(i)], tab[r].hdr[32*i +: 32]);
   endtask

   initial begin : main
      logic [31:0]  w;
      logic [255:0] kat;
      int w0, d0, t0;

      // Vector table: stimulus plus model-computed expectations.
      tab[0].maddr = 16'd0;      tab[0].oaddr = 16'd1000;   tab[0].hold = 2; tab[0].repulse = 1'b0;
      tab[1].maddr = 16'd200;    tab[1].oaddr = 16'd5000;   tab[1].hold = 1; tab[1].repulse = 1'b0;
      tab[2].maddr = 16'hFFFA;   tab[2].oaddr = 16'h7FF8;   tab[2].hold = 3; tab[2].repulse = 1'b1;
      tab[3].maddr = 16'd300;    tab[3].oaddr = 16'hFFF8;   tab[3].hold = 1; tab[3].repulse = 1'b0;
      w = 32'h0123_4567;
      for (int i = 0; i < 19; i++) begin
         tab[0].hdr[32*i +: 32] = w;
         w = {w[30:0], w[31]};
         tab[1].hdr[32*i +: 32] = 32'hFFFF_FFFF;
         tab[2].hdr[32*i +: 32] = $urandom;
         tab[3].hdr[32*i +: 32] = $urandom;
      end
      for (int r = 0; r < 4; r++) model(tab[r].hdr, tab[r].exp, tab[r].mid);

      // Known-answer sanity of the reference model: SHA-256("abc").
      kat = compress(IV_T, {32'h6162_6380, 448'h0, 32'h0000_0018});
      chk("model_kat_abc", kat[255:224] ^ kat[31:0], 32'hba7816bf ^ 32'hf20015ad);

      repeat (3) @(negedge clk);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_write_data, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int r = 0; r < 4; r++) run_vec(r);

      // Abort during BLK2 with a 2-cycle reset, then rerun cleanly.
      load_vec(0);
      @(negedge clk);
      w0 = wr_cnt; d0 = done_cnt;
      message_addr = tab[0].maddr;
      output_addr  = tab[0].oaddr;
      start        = 1'b1;
      t0           = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      while (cyc - t0 < 110) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort_mem_we_in_reset", 32'(mem_we), 32'd0);
      chk("abort_done_in_reset", 32'(done), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("abort_no_writes", 32'(wr_cnt - w0), 32'd0);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      chk("abort_result_untouched", mem[tab[0].oaddr], 32'hDEAD_0000);
      run_vec(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
